// File: rtl/mp3_spi_sched.sv
// mp3_spi_sched
// Scheduler for the MP3 decoder's shared SPI bus.
//
// After reset, or after hw_rst_req, the decoder reset pin is held low for
// RST_CYCLES clocks. The block then accepts 32-bit words from two requesters
// and shifts each one out MSB-first on mp3_mosi/mp3_sclk:
//   * commands (SCI) framed by mp3_cs
//   * stream data (SDI) framed by mp3_dcs
// Commands always win over stream data. A word may start only while
// mp3_dreq is high.
//
// Ports
//   clk, RST          bit-rate clock; synchronous active-low reset
//   hw_rst_req        one-cycle request: abort any word, redo decoder reset
//   cmd_valid/data    command word request   -> cmd_ready
//   dat_valid/data    stream word request    -> dat_ready
//   mp3_dreq          decoder ready (already synchronised)
//   mp3_rst           decoder reset, active-low
//   mp3_cs, mp3_dcs   SCI / SDI selects, active-low
//   mp3_mosi          serial data
//   mp3_sclk          serial clock, clk/2, idles at 0
//   xfer_done         one-cycle pulse when a word completes
//   busy              high whenever the FSM is not IDLE
//   dbg_state         current FSM state, for checkers and debug
module mp3_spi_sched #(
  parameter int RST_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        hw_rst_req,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  input  logic        dat_valid,
  input  logic [31:0] dat_data,
  output logic        dat_ready,
  input  logic        mp3_dreq,
  output logic        mp3_rst,
  output logic        mp3_cs,
  output logic        mp3_dcs,
  output logic        mp3_mosi,
  output logic        mp3_sclk,
  output logic        xfer_done,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // The reset counter only has to reach RST_CYCLES-1.
  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HWRST = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rst_n_q, rst_n_d;
  logic           cs_q, cs_d;
  logic           dcs_q, dcs_d;
  logic           sclk_q, sclk_d;
  logic [31:0]    shreg_q, shreg_d;
  logic [5:0]     bit_cnt_q, bit_cnt_d;
  logic           done_q, done_d;
  logic           cmd_fire, dat_fire;

  // Handshake: a word transfers on the rising clk edge where valid and ready
  // are both high. Ready is combinational from the registered state and
  // mp3_dreq; the requester must hold valid and data stable until that edge.
  // dat_ready is masked by cmd_valid so a pending command always goes first.
  assign cmd_ready = (state_q == ST_IDLE) && mp3_dreq;
  assign dat_ready = (state_q == ST_IDLE) && mp3_dreq && !cmd_valid;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign dat_fire  = dat_valid && dat_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_n_d   = rst_n_q;
    cs_d      = cs_q;
    dcs_d     = dcs_q;
    sclk_d    = sclk_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_HWRST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          rst_n_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        // mp3_dreq only matters here; once a word starts it always finishes.
        if (cmd_fire || dat_fire) begin
          shreg_d   = cmd_fire ? cmd_data : dat_data;
          cs_d      = !cmd_fire;
          dcs_d     = cmd_fire;
          sclk_d    = 1'b0;
          bit_cnt_d = 6'd1;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        sclk_d = !sclk_q;
        // Data changes on the falling SCLK edge, i.e. the cycle after the
        // decoder has sampled the current bit on the rising edge.
        if (sclk_q) begin
          if (bit_cnt_q != 6'd32) begin
            shreg_d   = {shreg_q[30:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            cs_d    = 1'b1;
            dcs_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_HWRST;
      end
    endcase

    // A hardware-reset request overrides everything and drops any word in
    // flight without a completion pulse.
    if (hw_rst_req) begin
      state_d   = ST_HWRST;
      cnt_d     = '0;
      rst_n_d   = 1'b0;
      cs_d      = 1'b1;
      dcs_d     = 1'b1;
      sclk_d    = 1'b0;
      shreg_d   = '0;
      bit_cnt_d = '0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q   <= ST_HWRST;
      cnt_q     <= '0;
      rst_n_q   <= 1'b0;
      cs_q      <= 1'b1;
      dcs_q     <= 1'b1;
      sclk_q    <= 1'b0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_n_q   <= rst_n_d;
      cs_q      <= cs_d;
      dcs_q     <= dcs_d;
      sclk_q    <= sclk_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
    end
  end

  // MOSI comes straight from the top of the shift register. It therefore
  // keeps the last bit sent until the next word loads, and reads 0 after reset.
  assign mp3_mosi  = shreg_q[31];
  assign mp3_rst   = rst_n_q;
  assign mp3_cs    = cs_q;
  assign mp3_dcs   = dcs_q;
  assign mp3_sclk  = sclk_q;
  assign xfer_done = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mp3_spi_sched.sv
// tb_mp3_spi_sched
// Testbench for mp3_spi_sched with RST_CYCLES = 8.
//
// Expected words, each tagged with its select, go into exp_q when stimulus
// is issued. A forked monitor rebuilds each word from the serial pins. It
// samples MOSI on every SCLK rise and pops and compares an entry on every
// xfer_done. Timing checks (reset length, accept spacing, abort behaviour)
// are made in the main thread against edge counts.
module tb_mp3_spi_sched;

  logic        clk = 1'b0;
  logic        RST;
  logic        hw_rst_req;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        dat_valid;
  logic [31:0] dat_data;
  logic        dat_ready;
  logic        mp3_dreq;
  logic        mp3_rst;
  logic        mp3_cs;
  logic        mp3_dcs;
  logic        mp3_mosi;
  logic        mp3_sclk;
  logic        xfer_done;
  logic        busy;
  logic [1:0]  dbg_state;

  mp3_spi_sched #(.RST_CYCLES(8)) dut (
    .clk        (clk),
    .RST        (RST),
    .hw_rst_req (hw_rst_req),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .dat_valid  (dat_valid),
    .dat_data   (dat_data),
    .dat_ready  (dat_ready),
    .mp3_dreq   (mp3_dreq),
    .mp3_rst    (mp3_rst),
    .mp3_cs     (mp3_cs),
    .mp3_dcs    (mp3_dcs),
    .mp3_mosi   (mp3_mosi),
    .mp3_sclk   (mp3_sclk),
    .xfer_done  (xfer_done),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset / edge counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];   // {is_cmd, word}
  logic [31:0] cmd_src[$];
  logic [31:0] dat_src[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic monitor_loop();
    logic        sel_prev  = 1'b0;
    logic        sclk_prev = 1'b0;
    logic        cur_cmd   = 1'b0;
    logic        overlap   = 1'b0;
    logic [31:0] rx        = '0;
    int          bits      = 0;
    int          low_cnt   = 0;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!mp3_cs || !mp3_dcs) begin
        if (!sel_prev) begin
          cur_cmd = !mp3_cs;
          bits    = 0;
          low_cnt = 0;
          rx      = '0;
          overlap = 1'b0;
        end
        low_cnt++;
        if (!mp3_cs && !mp3_dcs) overlap = 1'b1;
      end
      if (mp3_sclk && !sclk_prev) begin
        rx = {rx[30:0], mp3_mosi};
        bits++;
      end
      if (xfer_done) begin
        check("done_has_expected_word", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("serial_word", rx, e[31:0]);
          check("select_is_cmd", 32'(cur_cmd), 32'(e[32]));
          check("sclk_rises", 32'(bits), 32'd32);
          check("select_low_cycles", 32'(low_cnt), 32'd64);
          check("select_overlap", 32'(overlap), 32'd0);
          check("pins_at_done", 32'({mp3_cs, mp3_dcs, mp3_sclk}), 32'h6);
        end
      end
      sel_prev  = !mp3_cs || !mp3_dcs;
      sclk_prev = mp3_sclk;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present a word and wait for its handshake. acc_edge is the index of the
  // rising edge that accepts it.
  task automatic send(input bit is_cmd, input logic [31:0] w, input bit drop,
                      output int acc_edge);
    int n;
    bit fired;
    n = 0;
    fired = 1'b0;
    acc_edge = -1;
    while (!fired && n < 400) begin
      @(negedge clk);
      if (is_cmd) begin cmd_valid = 1'b1; cmd_data = w; end
      else        begin dat_valid = 1'b1; dat_data = w; end
      #1;
      fired = is_cmd ? (cmd_valid && cmd_ready) : (dat_valid && dat_ready);
      n++;
    end
    if (fired) acc_edge = cyc + 1;
    check("accept_seen", 32'(fired), 32'd1);
    if (drop) begin
      @(negedge clk);
      if (is_cmd) cmd_valid = 1'b0; else dat_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output int done_edge);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    done_edge = -1;
    while (!seen && n < 200) begin
      @(negedge clk);
      seen = xfer_done;
      n++;
    end
    if (seen) done_edge = cyc;
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_rst_rise(output int rise_edge, output int dones);
    int n;
    n = 0;
    dones = 0;
    rise_edge = -1;
    while (rise_edge < 0 && n < 200) begin
      @(negedge clk);
      if (xfer_done) dones++;
      if (mp3_rst) rise_edge = cyc;
      n++;
    end
    check("rst_rise_seen", 32'(rise_edge >= 0), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", 32'(exp_q.size()), 32'd0);
  endtask

  // Both requesters at once. Reference rule: every command queued here is
  // sent before any data word queued here.
  task automatic run_sources(input int budget);
    int n;
    bit cf, df;
    n = 0;
    while ((cmd_src.size() != 0 || dat_src.size() != 0) && n < budget) begin
      @(negedge clk);
      cmd_valid = (cmd_src.size() != 0);
      if (cmd_valid) cmd_data = cmd_src[0];
      dat_valid = (dat_src.size() != 0);
      if (dat_valid) dat_data = dat_src[0];
      mp3_dreq = ($urandom_range(0, 3) != 0);
      #1;
      cf = cmd_valid && cmd_ready;
      df = dat_valid && dat_ready;
      if (cf || df) check("single_grant", 32'(cf && df), 32'd0);
      if (cf) void'(cmd_src.pop_front());
      if (df) void'(dat_src.pop_front());
      n++;
    end
    check("sources_empty", 32'(cmd_src.size() + dat_src.size()), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    dat_valid = 1'b0;
    mp3_dreq  = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rel, rise, acc, acc2, dn, dones, h, early;
    logic [31:0] w;

    RST = 1'b0; hw_rst_req = 1'b0; cmd_valid = 1'b0; dat_valid = 1'b0;
    cmd_data = '0; dat_data = '0; mp3_dreq = 1'b1;
    fork monitor_loop(); join_none

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_pins", 32'({mp3_rst, mp3_cs, mp3_dcs, mp3_sclk, mp3_mosi, xfer_done, busy}),
          32'b0110001);

    // Reset release: mp3_rst goes high 8 edges later; cmd_ready rises with it
    RST = 1'b1;
    rel = cyc;
    wait_rst_rise(rise, dones);
    check("rst_release_len", 32'(rise - rel), 32'd8);
    check("ready_with_rst", 32'({cmd_ready, busy, mp3_cs, mp3_dcs}), 32'b1011);

    // Single command
    exp_q.push_back({1'b1, 32'h020B2020});
    send(1'b1, 32'h020B2020, 1'b1, acc);
    wait_done(dn);
    check("cmd_done_latency", 32'(dn - acc), 32'd64);
    check("gap_not_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(xfer_done), 32'd0);
    check("ready_back_at_t66", 32'({cmd_ready, 32'(cyc + 1 - acc) == 32'd66}), 32'b11);

    // Command and data both held: command first, data accepted at T66
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 32'h0203_1234;
    dat_valid = 1'b1; dat_data = 32'hC0DE_F00D;
    exp_q.push_back({1'b1, 32'h0203_1234});
    exp_q.push_back({1'b0, 32'hC0DE_F00D});
    #1;
    check("both_cmd_ready", 32'(cmd_ready), 32'd1);
    check("both_dat_blocked", 32'(dat_ready), 32'd0);
    acc = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    send(1'b0, 32'hC0DE_F00D, 1'b1, acc2);
    check("data_after_cmd_t66", 32'(acc2 - acc), 32'd66);
    wait_drain(300);

    // mp3_dreq low holds off the start; raising it accepts on that edge
    @(negedge clk);
    mp3_dreq = 1'b0; dat_valid = 1'b1; dat_data = 32'h1357_9BDF;
    early = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (dat_ready || busy) early++;
    end
    check("dreq_low_no_accept", 32'(early), 32'd0);
    @(negedge clk);
    mp3_dreq = 1'b1;
    exp_q.push_back({1'b0, 32'h1357_9BDF});
    #1;
    check("dreq_rise_ready", 32'(dat_ready), 32'd1);
    acc = cyc + 1;
    @(negedge clk);
    dat_valid = 1'b0;
    while (cyc < acc + 10) @(negedge clk);
    mp3_dreq = 1'b0;  // drop during bit 5; the word must still complete
    wait_done(dn);
    check("dreq_drop_completes", 32'(dn - acc), 32'd64);
    mp3_dreq = 1'b1;
    wait_drain(300);

    // hw_rst_req at bit 10 of a data word: abort, no done, reset re-runs
    send(1'b0, 32'hA5A5A5A5, 1'b1, acc);
    while (cyc < acc + 21) @(negedge clk);
    hw_rst_req = 1'b1;
    h = cyc + 1;
    @(negedge clk);
    hw_rst_req = 1'b0;
    check("abort_pins", 32'({mp3_dcs, mp3_sclk, mp3_rst, busy}), 32'b1001);
    wait_rst_rise(rise, dones);
    check("abort_rst_len", 32'(rise - h), 32'd8);
    check("abort_no_done", 32'(dones), 32'd0);

    // hw_rst_req during HWRST restarts the count
    @(negedge clk);
    hw_rst_req = 1'b1;
    h = cyc + 1;
    @(negedge clk);
    hw_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    hw_rst_req = 1'b1;
    h = cyc + 1;
    @(negedge clk);
    hw_rst_req = 1'b0;
    wait_rst_rise(rise, dones);
    check("restart_rst_len", 32'(rise - h), 32'd8);

    // Back-to-back data words
    exp_q.push_back({1'b0, 32'hFFFF_FFFF});
    exp_q.push_back({1'b0, 32'h0000_0000});
    send(1'b0, 32'hFFFF_FFFF, 1'b0, acc);
    send(1'b0, 32'h0000_0000, 1'b1, acc2);
    check("back_to_back_period", 32'(acc2 - acc), 32'd66);
    wait_drain(300);

    // Random mixes of commands and data under a toggling mp3_dreq
    for (int r = 0; r < 6; r++) begin
      int nc, nd;
      nc = $urandom_range(0, 3);
      nd = $urandom_range(1, 3);
      for (int i = 0; i < nc; i++) begin
        w = $urandom;
        cmd_src.push_back(w);
        exp_q.push_back({1'b1, w});
      end
      for (int i = 0; i < nd; i++) begin
        w = $urandom;
        dat_src.push_back(w);
        exp_q.push_back({1'b0, w});
      end
      run_sources(3000);
      wait_drain(400);
    end

    repeat (5) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
